// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - instruction fetch front end with PC-tagged prefetch FIFO
//
// Fetches sequential 32-bit words from instruction memory over a req/ack
// handshake (one request outstanding at most), buffers {pc, instruction}
// pairs in a circular FIFO and hands them to decode over valid/ready.
// A redirect flushes everything and restarts fetch at the target.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   redirect     flush queue and in-flight fetch, restart at redirect_pc
//   redirect_pc  branch/jump target (low two bits ignored)
//   imem_req     fetch request to instruction memory
//   imem_addr    fetch address, stable while imem_req is high
//   imem_ack     memory response valid; transfer on imem_req & imem_ack
//   imem_rdata   instruction word returned with imem_ack
//   instr_valid  head entry available to decode
//   instr_ready  decode accepts the head entry
//   instruction  head instruction word (0 when empty)
//   pc           PC of the head instruction (0 when empty)
//   queue_count  number of occupied FIFO entries

module fetch_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       redirect,
   input  logic [63:0]                redirect_pc,
   output logic                       imem_req,
   output logic [63:0]                imem_addr,
   input  logic                       imem_ack,
   input  logic [31:0]                imem_rdata,
   output logic                       instr_valid,
   input  logic                       instr_ready,
   output logic [31:0]                instruction,
   output logic [63:0]                pc,
   output logic [$clog2(DEPTH+1)-1:0] queue_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [63:0]     fetch_pc;
   // Address of a request abandoned by a redirect; must stay on the bus
   // until memory acknowledges it.
   logic [63:0]     hold_addr;
   logic [63:0]     redirect_target;

   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_after;

   logic [63:0]     pc_mem    [DEPTH];
   logic [31:0]     instr_mem [DEPTH];

   logic            push;
   logic            pop;
   logic            not_full;
   logic            empty;

   // Masking keeps every bit of redirect_pc in use while forcing word alignment.
   assign redirect_target = redirect_pc & ~64'h3;

   assign empty       = (count == '0);
   assign not_full    = (count < CW'(DEPTH));

   // A response that lands in a redirect cycle belongs to the old path.
   assign push        = (state == S_REQ) & imem_ack & ~redirect;
   // instr_valid already excludes redirect cycles, so pop does as well.
   assign pop         = instr_valid & instr_ready;
   assign count_after = count + CW'(push) - CW'(pop);

   // ------------------------------------------------------------------
   // Fetch FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      imem_req  = 1'b0;
      imem_addr = fetch_pc;
      case (state)
         S_IDLE: begin
            if (redirect || not_full) begin
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            imem_req = 1'b1;
            if (redirect) begin
               // With the ack in hand the old request is simply dropped;
               // without it we must wait out the abandoned request.
               state_nxt = imem_ack ? S_REQ : S_FLUSH;
            end else if (imem_ack) begin
               state_nxt = (count_after < CW'(DEPTH)) ? S_REQ : S_IDLE;
            end
         end
         S_FLUSH: begin
            imem_req  = 1'b1;
            imem_addr = hold_addr;
            if (imem_ack) begin
               state_nxt = S_REQ;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Fetch PC, abandoned-address latch and FIFO pointers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc  <= RESET_PC;
         hold_addr <= RESET_PC;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         if ((state == S_REQ) && redirect && !imem_ack) begin
            hold_addr <= fetch_pc;
         end

         if (redirect) begin
            fetch_pc <= redirect_target;
         end else if (push) begin
            fetch_pc <= fetch_pc + 64'd4;
         end

         if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_after;
         end
      end
   end

   // Storage needs no reset: entries are only read while count is non-zero.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= fetch_pc;
         instr_mem[wr_ptr] <= imem_rdata;
      end
   end

   // ------------------------------------------------------------------
   // Decode-side outputs
   // ------------------------------------------------------------------
   assign instr_valid = ~empty & ~redirect;
   assign instruction = empty ? 32'h0 : instr_mem[rd_ptr];
   assign pc          = empty ? 64'h0 : pc_mem[rd_ptr];
   assign queue_count = count;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - directed table-driven bench for fetch_prefetch_queue

module tb_fetch_prefetch_queue;

   logic        clk;
   logic        reset;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [63:0] pc;
   logic [2:0]  queue_count;

   int passed = 0;
   int total  = 0;
   int lat    = 0;

   typedef struct {
      logic        rd;
      logic [63:0] rpc;
      logic        rdy;
      logic        ev;
      logic [63:0] epc;
      int          ecnt;
      logic        ereq;
      logic [63:0] eaddr;
   } vec_t;

   vec_t vecs [21];

   fetch_prefetch_queue #(
      .DEPTH    (4),
      .RESET_PC (64'h100)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instruction (instruction),
      .pc          (pc),
      .queue_count (queue_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ 32'hDEAD_0000;
   endfunction

   function automatic vec_t mk(input logic rd, input logic [63:0] rpc, input logic rdy,
                               input logic ev, input logic [63:0] epc, input int ecnt,
                               input logic ereq, input logic [63:0] eaddr);
      vec_t v;
      v.rd = rd; v.rpc = rpc; v.rdy = rdy;
      v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.ereq = ereq; v.eaddr = eaddr;
      return v;
   endfunction

   // Memory model: acks after 'lat' wait cycles, 'lat'=0 acks in the first cycle.
   initial begin
      int   w;
      logic xf;
      w          = 0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         xf = imem_req && imem_ack;
         #2;
         if (!imem_req) begin
            w        = 0;
            imem_ack = 1'b0;
         end else begin
            if (xf) w = 0;
            if (w >= lat) begin
               imem_ack   = 1'b1;
               imem_rdata = mem_word(imem_addr);
            end else begin
               imem_ack = 1'b0;
               w++;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic chk_all(input string tag, input logic ev, input logic [63:0] epc,
                          input int ecnt, input logic ereq, input logic [63:0] eaddr);
      chk({tag, " instr_valid"}, 64'(instr_valid), 64'(ev));
      chk({tag, " pc"}, pc, epc);
      chk({tag, " instruction"}, 64'(instruction), (ecnt != 0) ? 64'(mem_word(epc)) : 64'h0);
      chk({tag, " queue_count"}, 64'(queue_count), 64'(ecnt));
      chk({tag, " imem_req"}, 64'(imem_req), 64'(ereq));
      chk({tag, " imem_addr"}, imem_addr, eaddr);
   endtask

   // One clock: drive this cycle's inputs 1 after the edge, sample 3 after.
   task automatic cyc(input logic rd, input logic [63:0] rpc, input logic rdy, input int l);
      @(posedge clk);
      #1;
      redirect    = rd;
      redirect_pc = rpc;
      instr_ready = rdy;
      lat         = l;
      #2;
   endtask

   initial begin
      reset       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 64'h0;
      instr_ready = 1'b0;

      // Zero-wait streaming, then backpressure to a full queue and drain,
      // then a wrapping redirect target.
      vecs[0]  = mk(0, 64'h0, 1, 0, 64'h0,   0, 1, 64'h100);
      vecs[1]  = mk(0, 64'h0, 1, 1, 64'h100, 1, 1, 64'h104);
      vecs[2]  = mk(0, 64'h0, 1, 1, 64'h104, 1, 1, 64'h108);
      vecs[3]  = mk(0, 64'h0, 1, 1, 64'h108, 1, 1, 64'h10C);
      vecs[4]  = mk(1, 64'h0, 0, 0, 64'h10C, 1, 1, 64'h110);
      vecs[5]  = mk(0, 64'h0, 0, 0, 64'h0,   0, 1, 64'h0);
      vecs[6]  = mk(0, 64'h0, 0, 1, 64'h0,   1, 1, 64'h4);
      vecs[7]  = mk(0, 64'h0, 0, 1, 64'h0,   2, 1, 64'h8);
      vecs[8]  = mk(0, 64'h0, 0, 1, 64'h0,   3, 1, 64'hC);
      vecs[9]  = mk(0, 64'h0, 0, 1, 64'h0,   4, 0, 64'h10);
      vecs[10] = mk(0, 64'h0, 1, 1, 64'h0,   4, 0, 64'h10);
      vecs[11] = mk(0, 64'h0, 1, 1, 64'h4,   3, 0, 64'h10);
      vecs[12] = mk(0, 64'h0, 1, 1, 64'h8,   2, 1, 64'h10);
      vecs[13] = mk(0, 64'h0, 1, 1, 64'hC,   2, 1, 64'h14);
      vecs[14] = mk(0, 64'h0, 1, 1, 64'h10,  2, 1, 64'h18);
      vecs[15] = mk(0, 64'h0, 1, 1, 64'h14,  2, 1, 64'h1C);
      vecs[16] = mk(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 64'h18, 2, 1, 64'h20);
      vecs[17] = mk(0, 64'h0, 1, 0, 64'h0,   0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
      vecs[18] = mk(0, 64'h0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 64'h0);
      vecs[19] = mk(0, 64'h0, 1, 1, 64'h0,   1, 1, 64'h4);
      vecs[20] = mk(0, 64'h0, 1, 1, 64'h4,   1, 1, 64'h8);

      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 0, 64'h0, 0, 0, 64'h100);

      @(posedge clk);
      #1;
      reset       = 1'b1;
      instr_ready = 1'b1;

      for (int i = 0; i < 21; i++) begin
         cyc(vecs[i].rd, vecs[i].rpc, vecs[i].rdy, 0);
         chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].ecnt,
                 vecs[i].ereq, vecs[i].eaddr);
      end

      // Redirect during a slow request at 0x20: the abandoned address stays
      // on the bus until acked, its data is discarded, fetch resumes at 0x400.
      cyc(1, 64'h20, 1, 0);
      chk("t3 setup valid", 64'(instr_valid), 64'h0);
      cyc(0, 64'h0, 1, 3);
      chk_all("t3 req20", 0, 64'h0, 0, 1, 64'h20);
      cyc(1, 64'h403, 1, 3);
      chk_all("t3 redir", 0, 64'h0, 0, 1, 64'h20);
      cyc(0, 64'h0, 1, 3);
      chk_all("t3 flush1", 0, 64'h0, 0, 1, 64'h20);
      cyc(0, 64'h0, 1, 3);
      chk_all("t3 flush2", 0, 64'h0, 0, 1, 64'h20);
      cyc(0, 64'h0, 1, 0);
      chk_all("t3 req400", 0, 64'h0, 0, 1, 64'h400);
      cyc(0, 64'h0, 0, 0);
      chk_all("t3 first", 1, 64'h400, 1, 1, 64'h404);

      // Redirect coincident with an ack and a would-be pop at count 2.
      cyc(1, 64'h800, 1, 0);
      chk_all("t4 redir", 0, 64'h400, 2, 1, 64'h408);
      cyc(0, 64'h0, 1, 0);
      chk_all("t4 after", 0, 64'h0, 0, 1, 64'h800);
      cyc(1, 64'h1000, 1, 5);
      chk_all("t4 target", 0, 64'h800, 1, 1, 64'h804);

      // Enter FLUSH, then assert reset mid-cycle.
      cyc(0, 64'h0, 1, 5);
      chk_all("t6 flush", 0, 64'h0, 0, 1, 64'h804);
      #2;
      reset = 1'b0;
      #1;
      chk_all("t6 async", 0, 64'h0, 0, 0, 64'h100);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      lat   = 0;
      cyc(0, 64'h0, 1, 0);
      chk_all("t6 req", 0, 64'h0, 0, 1, 64'h100);
      cyc(0, 64'h0, 1, 0);
      chk_all("t6 first", 1, 64'h100, 1, 1, 64'h104);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Instruction-fetch front end for the pipelined datapath. Sits directly upstream of the decode stage.
- Fetches sequential 32-bit instructions from instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers fetched instructions with their PCs in a small FIFO and presents them to decode over a valid/ready interface.
- On a branch redirect, flushes all buffered and in-flight fetches and restarts at the target.

Parameters:
- DEPTH, 4: FIFO entries (power of two, ≥2).
- RESET_PC, 64'h0: first fetch address after reset.

Ports:
- clk  in  1  the single clock, rising-edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- redirect  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  64  branch/jump target.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  64  fetch address; stable while imem_req=1.
- imem_ack  in  1  memory response valid; a transfer completes on a rising edge with imem_req & imem_ack.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- instr_valid  out  1  head entry available to decode.
- instr_ready  in  1  decode accepts the head entry.
- instruction  out  32  head instruction.
- pc  out  64  PC of the head instruction.
- queue_count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc = RESET_PC; FSM = IDLE; FIFO emptied.
  - imem_req = 0, imem_addr = RESET_PC, instr_valid = 0, instruction = 0, pc = 0, queue_count = 0.
  - Reset mid-request abandons the request; imem_req drops immediately.
- FSM states and transitions:
  - IDLE: imem_req = 0. Moves to REQ at the next edge if queue_count < DEPTH.
  - REQ: imem_req = 1, imem_addr = fetch_pc.
    - On ack without redirect: push {fetch_pc, imem_rdata}; fetch_pc += 4 (wraps mod 2^64). Stay in REQ if the post-edge count < DEPTH, else go to IDLE.
    - On redirect without ack: go to FLUSH.
    - On redirect with ack: drop the data and stay in REQ.
  - FLUSH: imem_req held at 1, imem_addr held at the abandoned address (handshake rule: address must not change while req is high).
    - On ack: the response is discarded; go to REQ.
    - Further redirects only update fetch_pc.
- Handshake rules:
  - At most one outstanding request.
  - imem_ack may arrive in the first cycle of imem_req (zero-wait memory). This sustains 1 instruction/cycle.
- Redirect (any state):
  - fetch_pc = {redirect_pc[63:2], 2'b00}; FIFO cleared at the same edge.
  - instr_valid is forced to 0 combinationally while redirect=1, so no decode handshake completes in a redirect cycle.
  - In IDLE, a redirect moves to REQ.
- FIFO:
  - Circular buffer with read/write pointers that wrap at DEPTH.
  - Pop on instr_valid & instr_ready; push only as described above.
  - Push and pop on the same edge leave count unchanged.
  - A request is issued only when count < DEPTH, so a push can never overflow.
  - Pop when empty is impossible because instr_valid = 0.
- Outputs:
  - instr_valid = (count ≠ 0) & ~redirect.
  - instruction and pc show the head entry. They read 0 when empty.
  - Fetch-to-decode latency: an instruction acked at edge N is visible at decode after edge N (same cycle as count increments).

Test Plan:
1. Zero-wait memory (ack tied 1 while req), instr_ready=1, RESET_PC=0x100 → decode sees pc 0x100, 0x104, 0x108… one per cycle from the 2nd cycle after reset release; queue_count ≤ 1.
2. Backpressure: instr_ready=0, zero-wait memory → exactly 4 entries fetched (0x0–0xC); queue_count=4, imem_req=0. Raise instr_ready → entries drain in order and fetching resumes at 0x10.
3. Redirect during a 3-cycle-latency request at addr 0x20 with redirect_pc=0x403 → imem_addr stays 0x20 until ack; that data is discarded. Next request addr is 0x400; FIFO empty; instr_valid=0 in the redirect cycle.
4. Redirect coincident with ack and with a pending pop (instr_ready=1, count=2) → count becomes 0, no push, no handshake counted; the next request is at the redirect target.
5. Wrap-around: redirect_pc=64'hFFFF_FFFF_FFFF_FFFC → fetches at …FFFC then 0x0; FIFO pointers wrap after 4+ push/pop cycles without losing order.
6. Reset asserted while imem_req=1 in FLUSH → imem_req, instr_valid and queue_count are 0 immediately, before the next clock edge. After release, the first request is at RESET_PC.
